// File: rtl/serial_word_collector_pkg.sv
// serial_word_collector_pkg: shared constants, FSM state type and comma-search helper
package serial_word_collector_pkg;
  localparam logic [2:0] COMMA_CODE = 3'b101;
  localparam int WORD_SIZE_DEF = 16;
  localparam int INDEX_SIZE_DEF = 4;
  typedef enum logic [1:0] {
    SWC_IDLE  = 2'd0,
    SWC_SETUP = 2'd1,
    SWC_PULSE = 2'd2
  } swc_state_t;
  // Position of the most significant bit of the highest 3'b101 match, 0 when none
  function automatic logic [INDEX_SIZE_DEF-1:0] comma_index(input logic [WORD_SIZE_DEF-1:0] w);
    logic [INDEX_SIZE_DEF-1:0] idx;
    idx = '0;
    for (int i = 2; i < WORD_SIZE_DEF; i++)
      if (w[i -: 3] == COMMA_CODE) idx = INDEX_SIZE_DEF'(i);
    return idx;
  endfunction
endpackage

// File: rtl/serial_word_collector_trigger_pulse_gen.sv
// serial_word_collector_trigger_pulse_gen: setup cycle then fixed-width trigger pulse per word
module serial_word_collector_trigger_pulse_gen
  import serial_word_collector_pkg::*;
#(
  parameter int TRIG_HIGH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic trigger,
  output logic busy
);
  localparam int PW = $clog2(TRIG_HIGH + 1);
  swc_state_t state;
  logic [PW-1:0] pulse_cnt;
  assign busy = state != SWC_IDLE;
  // Presentation FSM: one low SETUP cycle, then TRIG_HIGH cycles of registered trigger
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= SWC_IDLE;
      pulse_cnt <= '0;
      trigger <= 1'b0;
    end else begin
      case (state)
        SWC_IDLE: if (start) state <= SWC_SETUP;
        SWC_SETUP: begin
          state <= SWC_PULSE;
          pulse_cnt <= '0;
          trigger <= 1'b1;
        end
        SWC_PULSE:
          if (pulse_cnt == PW'(TRIG_HIGH - 1)) begin
            state <= SWC_IDLE;
            trigger <= 1'b0;
          end else pulse_cnt <= pulse_cnt + PW'(1);
        default: begin
          state <= SWC_IDLE;
          trigger <= 1'b0;
        end
      endcase
    end
endmodule

// File: rtl/serial_word_collector.sv
// serial_word_collector: MSB-first serial-to-word assembly with triggered word presentation
module serial_word_collector
  import serial_word_collector_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int COUNT_SIZE = 5,
  parameter int TRIG_HIGH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  bit_clear,
  output logic [WORD_SIZE-1:0]  word_out,
  output logic                  trigger,
  output logic [COUNT_SIZE-1:0] bit_count,
  output logic                  overrun
);
  logic [WORD_SIZE-1:0] shift_reg;
  logic [WORD_SIZE-1:0] next_word;
  logic word_done;
  logic busy;
  assign next_word = {shift_reg[WORD_SIZE-2:0], bit_in};
  assign word_done = bit_valid && !bit_clear && bit_count == COUNT_SIZE'(WORD_SIZE - 1);
  // Assembly keeps running while a word presents; a word finishing mid-presentation is dropped
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      shift_reg <= '0;
      bit_count <= '0;
      word_out <= '0;
      overrun <= 1'b0;
    end else begin
      if (bit_clear) begin
        shift_reg <= '0;
        bit_count <= '0;
      end else if (bit_valid) begin
        shift_reg <= next_word;
        bit_count <= word_done ? '0 : bit_count + COUNT_SIZE'(1);
      end
      if (word_done && !busy) word_out <= next_word;
      if (word_done && busy) overrun <= 1'b1;
    end
  serial_word_collector_trigger_pulse_gen #(.TRIG_HIGH(TRIG_HIGH)) u_pulse (
    .clock  (clock),
    .reset  (reset),
    .start  (word_done && !busy),
    .trigger(trigger),
    .busy   (busy)
  );
endmodule

// File: tb/tb_serial_word_collector.sv
// tb_serial_word_collector: directed self-checking bench for serial_word_collector
module tb_serial_word_collector;
  import serial_word_collector_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_clear = 1'b0;
  logic [15:0] word_out, word_out2;
  logic trigger, trigger2, overrun, overrun2;
  logic [4:0] bit_count, bit_count2;
  int checks = 0;
  int failures = 0;
  int rises = 0;
  int viol = 0;
  logic pt = 1'b0;
  logic [15:0] pw = '0;

  always #5 clock = ~clock;

  serial_word_collector dut (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .bit_clear(bit_clear),
    .word_out(word_out), .trigger(trigger), .bit_count(bit_count), .overrun(overrun)
  );

  serial_word_collector #(.TRIG_HIGH(15)) dut_slow (
    .clock(clock), .reset(reset2), .bit_in(bit_in), .bit_valid(bit_valid), .bit_clear(bit_clear),
    .word_out(word_out2), .trigger(trigger2), .bit_count(bit_count2), .overrun(overrun2)
  );

  // Mid-cycle observer: counts trigger rises and word_out changes made while trigger was high
  always @(negedge clock) begin
    if (trigger && !pt) rises <= rises + 1;
    if (word_out !== pw && pt) viol <= viol + 1;
    pt <= trigger;
    pw <= word_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    int hi, r0, v0;
    tick();
    tick();
    chk("rst_word", 32'(word_out), 32'h0);
    chk("rst_trig", 32'(trigger), 32'h0);
    chk("rst_cnt", 32'(bit_count), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    reset = 1'b0;
    tick();
    // Single word A005: setup cycle, 4-cycle pulse, comma found at bit 15
    send_word(16'hA005);
    chk("a005_word", 32'(word_out), 32'hA005);
    chk("a005_setup_low", 32'(trigger), 32'h0);
    chk("a005_cnt", 32'(bit_count), 32'h0);
    tick();
    chk("a005_rise", 32'(trigger), 32'h1);
    hi = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (trigger) hi++;
      else break;
    end
    chk("a005_high_cycles", 32'(hi), 32'd4);
    chk("a005_hold", 32'(word_out), 32'hA005);
    chk("a005_index", 32'(comma_index(word_out)), 32'd15);
    tick();
    // Back-to-back words with no gap
    r0 = rises;
    v0 = viol;
    send_word(16'h0005);
    chk("b2b_first", 32'(word_out), 32'h0005);
    send_word(16'hFFFF);
    chk("b2b_second", 32'(word_out), 32'hFFFF);
    repeat (7) tick();
    chk("b2b_rises", 32'(rises - r0), 32'd2);
    chk("b2b_stable", 32'(viol - v0), 32'd0);
    chk("b2b_ovr", 32'(overrun), 32'h0);
    chk("b2b_trig_end", 32'(trigger), 32'h0);
    // Asynchronous reset while trigger is high and a word is partly assembled
    send_word(16'h5A5A);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("mid_trig_high", 32'(trigger), 32'h1);
    chk("mid_cnt", 32'(bit_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("async_trig", 32'(trigger), 32'h0);
    chk("async_word", 32'(word_out), 32'h0);
    chk("async_cnt", 32'(bit_count), 32'h0);
    chk("async_ovr", 32'(overrun), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    // Resync after 7 bits
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    chk("clr_pre_cnt", 32'(bit_count), 32'd7);
    bit_clear = 1'b1;
    tick();
    bit_clear = 1'b0;
    chk("clr_cnt", 32'(bit_count), 32'h0);
    send_word(16'h1234);
    chk("clr_word", 32'(word_out), 32'h1234);
    chk("clr_cnt_wrap", 32'(bit_count), 32'h0);
    repeat (6) tick();
    // Clear beats a simultaneous valid bit
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    bit_clear = 1'b1;
    send_bit(1'b1);
    bit_clear = 1'b0;
    chk("prio_cnt", 32'(bit_count), 32'h0);
    for (int i = 15; i >= 1; i--) send_bit(logic'(16'hBEEF >> i));
    chk("prio_cnt15", 32'(bit_count), 32'd15);
    chk("prio_hold", 32'(word_out), 32'h1234);
    send_bit(1'b1);
    chk("prio_word", 32'(word_out), 32'hBEEF);
    repeat (6) tick();
    // Long pulse instance: second word completes while still presenting
    reset2 = 1'b0;
    tick();
    chk("ovr_init", 32'(overrun2), 32'h0);
    send_word(16'h0005);
    chk("ovr_first", 32'(word_out2), 32'h0005);
    send_word(16'hFFFF);
    chk("ovr_set", 32'(overrun2), 32'h1);
    chk("ovr_hold_word", 32'(word_out2), 32'h0005);
    chk("ovr_cnt_wrap", 32'(bit_count2), 32'h0);
    chk("ovr_fast_clean", 32'(overrun), 32'h0);
    repeat (20) tick();
    chk("ovr_sticky", 32'(overrun2), 32'h1);
    chk("ovr_word_final", 32'(word_out2), 32'h0005);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
